// File: rtl/apb_uart_regbank.sv
// APB3 register bank for the UART core: BAUD/CTRL/TXDATA/RXDATA/STATUS with
// programmable wait states, error response, sticky overrun flag and interrupt.
module apb_uart_regbank #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] baud_val,
  output logic [DATA_W-1:0] ctrl,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr_stb,
  output logic              rx_rd_stb,
  input  logic              tx_full,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_overrun,
  output logic              irq
);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_e            state_q;
  logic [2:0]        wcnt_q;
  logic [DATA_W-1:0] baud_q, ctrl_q, tx_data_q;
  logic              ovf_q, ovf_d;
  logic              tx_stb_q, rx_stb_q, irq_q;

  logic [31:0]       addr_w;
  logic              err_c, complete_c, do_wr_c, do_rd_c;
  logic [DATA_W-1:0] rd_mux_c;

  assign addr_w = 32'(paddr);

  always_comb begin
    rd_mux_c = '0;
    case (addr_w)
      32'd0:   rd_mux_c = baud_q;
      32'd1:   rd_mux_c = ctrl_q;
      32'd2:   rd_mux_c = tx_data_q;
      32'd3:   rd_mux_c = rx_data;
      32'd4:   rd_mux_c = DATA_W'({ovf_q, rx_valid, ~tx_full});
      default: rd_mux_c = '0;
    endcase
  end

  assign err_c = (addr_w > 32'd4)
               | (pwrite  & (addr_w == 32'd3))
               | (pwrite  & (addr_w == 32'd2) & tx_full)
               | (~pwrite & (addr_w == 32'd3) & ~rx_valid);

  assign pready     = (state_q == S_ACCESS) && (wcnt_q == 3'd0);
  assign complete_c = psel & penable & pready;
  assign do_wr_c    = complete_c & pwrite  & ~err_c;
  assign do_rd_c    = complete_c & ~pwrite & ~err_c;
  assign pslverr    = pready & err_c;
  assign prdata     = (pready & ~pwrite & ~err_c) ? rd_mux_c : '0;

  // A coincident overrun pulse overrides the W1C clear.
  always_comb begin
    ovf_d = ovf_q;
    if (do_wr_c && (addr_w == 32'd4) && pwdata[2]) ovf_d = 1'b0;
    if (rx_overrun) ovf_d = 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 3'd0;
      baud_q    <= '0;
      ctrl_q    <= '0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
      tx_stb_q  <= 1'b0;
      rx_stb_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      tx_stb_q <= do_wr_c && (addr_w == 32'd2);
      rx_stb_q <= do_rd_c && (addr_w == 32'd3);
      irq_q    <= (ctrl_q[0] & ~tx_full) | (ctrl_q[1] & rx_valid) | (ctrl_q[2] & ovf_q);
      if (do_wr_c) begin
        case (addr_w)
          32'd0:   baud_q    <= pwdata;
          32'd1:   ctrl_q    <= pwdata;
          32'd2:   tx_data_q <= pwdata;
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE: begin
          if (psel && !penable) begin
            state_q <= S_ACCESS;
            wcnt_q  <= WS;
          end
        end
        S_ACCESS: begin
          if (!psel || complete_c) begin
            state_q <= S_IDLE;
            wcnt_q  <= 3'd0;
          end else if (wcnt_q != 3'd0) begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign baud_val  = baud_q;
  assign ctrl      = ctrl_q;
  assign tx_data   = tx_data_q;
  assign tx_wr_stb = tx_stb_q;
  assign rx_rd_stb = rx_stb_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_apb_uart_regbank.sv
// Bench for apb_uart_regbank: two instances (0 and 3 wait states) sharing one
// bus, checked against a register-map model of the UART register bank.
module tb_apb_uart_regbank;
  localparam int DW = 8;
  localparam int AW = 3;

  logic pclk = 1'b0;
  logic presetn;
  logic [1:0] psel;
  logic penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, rx_data;
  logic tx_full, rx_valid, rx_overrun;

  logic [1:0][DW-1:0] prdata, baud_val, ctrl, tx_data;
  logic [1:0] pready, pslverr, tx_wr_stb, rx_rd_stb, irq;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_baud [2];
  logic [DW-1:0] m_ctrl [2];
  logic [DW-1:0] m_txd  [2];
  bit            m_ovf  [2];

  always #5 pclk = ~pclk;

  apb_uart_regbank #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .baud_val(baud_val[0]),
    .ctrl(ctrl[0]), .tx_data(tx_data[0]), .tx_wr_stb(tx_wr_stb[0]),
    .rx_rd_stb(rx_rd_stb[0]), .tx_full(tx_full), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_overrun(rx_overrun), .irq(irq[0]));

  apb_uart_regbank #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(3)) u_dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .baud_val(baud_val[1]),
    .ctrl(ctrl[1]), .tx_data(tx_data[1]), .tx_wr_stb(tx_wr_stb[1]),
    .rx_rd_stb(rx_rd_stb[1]), .tx_full(tx_full), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_overrun(rx_overrun), .irq(irq[1]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_irq(input int d);
    return (m_ctrl[d][0] & ~tx_full) | (m_ctrl[d][1] & rx_valid) | (m_ctrl[d][2] & m_ovf[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_baud[d] = '0; m_ctrl[d] = '0; m_txd[d] = '0; m_ovf[d] = 1'b0;
    end
  endtask

  task automatic check_regs(input int d);
    check_eq($sformatf("baud%0d", d), baud_val[d], m_baud[d]);
    check_eq($sformatf("ctrl%0d", d), ctrl[d], m_ctrl[d]);
    check_eq($sformatf("txdata%0d", d), tx_data[d], m_txd[d]);
  endtask

  task automatic check_all_zero(input int d);
    check_eq($sformatf("rst_prdata%0d", d), prdata[d], 0);
    check_eq($sformatf("rst_pready%0d", d), pready[d], 0);
    check_eq($sformatf("rst_pslverr%0d", d), pslverr[d], 0);
    check_eq($sformatf("rst_baud%0d", d), baud_val[d], 0);
    check_eq($sformatf("rst_ctrl%0d", d), ctrl[d], 0);
    check_eq($sformatf("rst_txdata%0d", d), tx_data[d], 0);
    check_eq($sformatf("rst_txstb%0d", d), tx_wr_stb[d], 0);
    check_eq($sformatf("rst_rxstb%0d", d), rx_rd_stb[d], 0);
    check_eq($sformatf("rst_irq%0d", d), irq[d], 0);
  endtask

  // One complete APB transfer to instance d; ovr_end pulses rx_overrun on the completing edge.
  task automatic xfer(input int d, input bit wr, input int a, input logic [DW-1:0] wd,
                      input bit ovr_end);
    bit            ee;
    logic [DW-1:0] er;
    int            w;
    ee = (a >= 5) || (wr && a == 3) || (wr && a == 2 && tx_full) || (!wr && a == 3 && !rx_valid);
    er = '0;
    if (!ee && !wr) begin
      case (a)
        0: er = m_baud[d];
        1: er = m_ctrl[d];
        2: er = m_txd[d];
        3: er = rx_data;
        4: er = {5'b0, m_ovf[d], rx_valid, ~tx_full};
        default: er = '0;
      endcase
    end
    @(negedge pclk);
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = AW'(a); pwdata = wd;
    @(negedge pclk);
    penable = 1'b1;
    w = 0;
    while (!pready[d] && w < 20) begin
      @(negedge pclk);
      w++;
    end
    check_eq($sformatf("waits%0d", d), w, (d == 1) ? 3 : 0);
    if (!pready[d]) begin
      psel = '0; penable = 1'b0;
      return;
    end
    check_eq($sformatf("prdata%0d_a%0d", d, a), prdata[d], er);
    check_eq($sformatf("pslverr%0d_a%0d", d, a), pslverr[d], ee);
    if (ovr_end) rx_overrun = 1'b1;
    @(negedge pclk);
    rx_overrun = 1'b0; psel = '0; penable = 1'b0;
    if (!ee && wr) begin
      case (a)
        0: m_baud[d] = wd;
        1: m_ctrl[d] = wd;
        2: m_txd[d]  = wd;
        4: if (wd[2]) m_ovf[d] = 1'b0;
        default: ;
      endcase
    end
    if (ovr_end) begin m_ovf[0] = 1'b1; m_ovf[1] = 1'b1; end
    check_eq($sformatf("txstb%0d", d), tx_wr_stb[d], !ee && wr && a == 2);
    check_eq($sformatf("rxstb%0d", d), rx_rd_stb[d], !ee && !wr && a == 3);
    check_regs(d);
    @(negedge pclk);
    check_eq($sformatf("txstb_end%0d", d), tx_wr_stb[d], 0);
    check_eq($sformatf("rxstb_end%0d", d), rx_rd_stb[d], 0);
    check_eq("irq0", irq[0], exp_irq(0));
    check_eq("irq1", irq[1], exp_irq(1));
  endtask

  task automatic pulse_overrun();
    @(negedge pclk);
    rx_overrun = 1'b1;
    @(negedge pclk);
    rx_overrun = 1'b0;
    m_ovf[0] = 1'b1; m_ovf[1] = 1'b1;
    @(negedge pclk);
    check_eq("ovf_irq0", irq[0], exp_irq(0));
    check_eq("ovf_irq1", irq[1], exp_irq(1));
  endtask

  initial begin
    presetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_full = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_overrun = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    check_all_zero(0);
    check_all_zero(1);
    presetn = 1'b1;

    xfer(0, 1, 0, 8'h1B, 0);
    xfer(0, 0, 0, 8'h00, 0);

    tx_full = 1'b0; rx_valid = 1'b1;
    xfer(1, 0, 4, 8'h00, 0);

    rx_valid = 1'b0;
    xfer(0, 1, 2, 8'hA5, 0);
    tx_full = 1'b1;
    xfer(0, 1, 2, 8'h3C, 0);
    xfer(0, 0, 2, 8'h00, 0);

    xfer(0, 0, 6, 8'h00, 0);
    xfer(0, 1, 3, 8'h77, 0);
    xfer(0, 0, 3, 8'h00, 0);
    rx_valid = 1'b1; rx_data = 8'h5C;
    xfer(0, 0, 3, 8'h00, 0);

    tx_full = 1'b1; rx_valid = 1'b0;
    xfer(0, 1, 1, 8'h04, 0);
    pulse_overrun();
    xfer(0, 0, 4, 8'h00, 0);
    xfer(0, 1, 4, 8'h04, 1);
    xfer(0, 0, 4, 8'h00, 0);
    xfer(0, 1, 4, 8'hFB, 0);
    xfer(0, 1, 4, 8'h04, 0);
    xfer(0, 0, 4, 8'h00, 0);

    // Abort a BAUD write on the wait-state instance.
    @(negedge pclk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = '0; pwdata = 8'hEE;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check_eq("abort_pready", pready[1], 0);
    psel = '0; penable = 1'b0;
    @(negedge pclk);
    check_eq("abort_baud", baud_val[1], m_baud[1]);
    check_eq("abort_txstb", tx_wr_stb[1], 0);
    xfer(1, 0, 0, 8'h00, 0);
    xfer(1, 1, 0, 8'h42, 0);
    xfer(1, 0, 0, 8'h00, 0);

    for (int i = 0; i < 200; i++) begin
      tx_full  = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) pulse_overrun();
      xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
           8'($urandom), $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a ready TXDATA write on the zero-wait instance.
    tx_full = 1'b0; rx_valid = 1'b1;
    xfer(0, 1, 1, 8'h07, 0);
    @(negedge pclk);
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(2); pwdata = 8'h99;
    @(negedge pclk);
    penable = 1'b1;
    check_eq("pre_rst_pready", pready[0], 1);
    #2 presetn = 1'b0;
    #1;
    check_all_zero(0);
    check_all_zero(1);
    @(negedge pclk);
    check_eq("rst_nostb", tx_wr_stb[0], 0);
    check_eq("rst_notxd", tx_data[0], 0);
    psel = '0; penable = 1'b0;
    model_reset();
    presetn = 1'b1;
    xfer(0, 0, 2, 8'h00, 0);
    xfer(1, 0, 1, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_uart_regbank.md
# apb_uart_regbank

Parametrised APB register bank for the UART core. It replaces the fixed four-entry negedge slave with a rising-edge APB3 slave that supports configurable wait states, error response (`pslverr`), and a status register with a sticky overrun flag. It adds a maskable interrupt output and single-cycle strobes toward the transmit FIFO and receive buffer. It sits between the APB interconnect and the UART TX/RX datapaths.

## Interface
Parameters:
- `DATA_W`, 8: register and APB data width (8..32).
- `ADDR_W`, 3: word-address width; the map decodes `2**ADDR_W` slots, with 5 implemented.
- `WAIT_STATES`, 0: number of `pready`-low cycles inserted in each access phase (0..7).

Ports (one clock; reset is asynchronous and active-low):
- `pclk`  in  1  APB clock; all state changes on the rising edge.
- `presetn`  in  1  asynchronous active-low reset.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `paddr`  in  ADDR_W  word address.
- `pwdata`  in  DATA_W  write data.
- `prdata`  out  DATA_W  read data.
- `pready`  out  1  transfer-complete indication.
- `pslverr`  out  1  error response.
- `baud_val`  out  DATA_W  BAUD register contents.
- `ctrl`  out  DATA_W  CTRL register contents.
- `tx_data`  out  DATA_W  last accepted TXDATA write.
- `tx_wr_stb`  out  1  one-cycle push to the TX FIFO.
- `rx_rd_stb`  out  1  one-cycle pop from the RX buffer.
- `tx_full`  in  1  TX FIFO full.
- `rx_valid`  in  1  RX data available.
- `rx_data`  in  DATA_W  RX buffer head.
- `rx_overrun`  in  1  one-cycle pulse from the receiver on a dropped byte.
- `irq`  out  1  registered interrupt.

## Operation
- Register map by `paddr`:
  - 0 BAUD: RW, reset 0.
  - 1 CTRL: RW, reset 0. Bit 0 tx_ie, bit 1 rx_ie, bit 2 ovf_ie; other bits are storage only.
  - 2 TXDATA: RW. A write pushes to the TX FIFO; a read returns `tx_data`.
  - 3 RXDATA: RO. A read returns `rx_data` and pops the RX buffer.
  - 4 STATUS: bit 0 TX_RDY = `~tx_full`, bit 1 RX_RDY = `rx_valid`, bit 2 OVF (sticky, W1C); upper bits read 0.
  - 5 and above: unmapped.
- FSM states:
  - IDLE: `psel & ~penable` → ACCESS, loading `wcnt = WAIT_STATES`.
  - ACCESS: while `wcnt != 0`, decrement; `pready = (state==ACCESS) & (wcnt==0)`.
  - The transfer completes on the edge where `psel & penable & pready`; the FSM then returns to IDLE.
  - If `psel` drops in ACCESS → IDLE, with no side effects.
- Read data:
  - `prdata` carries the decoded register while `pready=1` and `~pwrite`; otherwise it is 0.
  - `prdata` is 0 on an error.
- `pslverr` is asserted only with `pready=1`, for any of:
  - an unmapped address;
  - a write to RXDATA;
  - a write to TXDATA while `tx_full=1`;
  - a read of RXDATA while `rx_valid=0`.
- An errored transfer has no side effects: no register update, no strobe.
- OVF behaviour:
  - Set by `rx_overrun`.
  - Cleared by a STATUS write with `pwdata[2]=1`.
  - If set and clear occur on the same edge, set wins.
  - Writes to other STATUS bits are ignored and return no error.
- `irq` is registered: `(tx_ie & ~tx_full) | (rx_ie & rx_valid) | (ovf_ie & OVF)`.

## Timing
- Reset values:
  - state IDLE, `wcnt` 0;
  - all registers, OVF, `prdata`, `pready`, `pslverr`, `irq`, `tx_wr_stb`, `rx_rd_stb` = 0.
- Access-phase length is `WAIT_STATES+1` cycles. With `WAIT_STATES=0`, `pready=1` in the first access cycle.
- Register writes take effect on the completing edge; the new value is visible on outputs in the next cycle.
- `tx_wr_stb` and `rx_rd_stb` are high for exactly the one cycle after the completing edge. `tx_data` updates on the same edge.
- Back-to-back transfers (setup immediately after completion) are supported with no idle cycle.
- `irq` lags its inputs by one cycle.
- Reset asserted mid-transfer forces reset values immediately. No strobe is issued, and no partial write is kept.

## Test plan
- **Reset, then write/read BAUD:** after reset, write 0x1B to addr 0 with `WAIT_STATES=0`, then read addr 0.
  - Required: `baud_val`=0x1B the cycle after completion.
  - Required: `prdata`=0x1B with `pready=1` in the first access cycle, `pslverr=0`.
- **Wait states:** with `WAIT_STATES=3`, read STATUS while `tx_full=0`, `rx_valid=1`.
  - Required: `pready` low for 3 access cycles, then high for 1 cycle with `prdata`=0x03.
- **TXDATA write:** write 0xA5 to addr 2 while `tx_full=0`.
  - Required: `tx_data`=0xA5 and a single `tx_wr_stb` pulse.
  - Repeat with `tx_full=1`. Required: `pslverr=1`, no strobe, `tx_data` stays 0xA5.
- **Errors and RXDATA pop:**
  - Read addr 6. Required: `pslverr=1`, `prdata`=0.
  - Write addr 3. Required: `pslverr=1`.
  - Read addr 3 with `rx_valid=1`, `rx_data`=0x5C. Required: `prdata`=0x5C and one `rx_rd_stb` pulse.
- **OVF and irq:** set CTRL=0x04, then pulse `rx_overrun`.
  - Required: OVF=1 and `irq`=1 one cycle later.
  - Write STATUS 0x04 with a coincident `rx_overrun`. Required: OVF stays 1.
  - Write STATUS 0x04 alone. Required: OVF=0, `irq`=0 the following cycle.
- **Abort and reset:**
  - Drop `psel` during wait states of a BAUD write. Required: BAUD unchanged, FSM back in IDLE.
  - Assert `presetn` low mid-access. Required: all outputs 0 immediately.
